elevator_call_latch: RTL
========================

Name: elevator_call_latch

Overview:
- Front-end request stage directly upstream of the `elevator` controller.
- Synchronises and debounces the raw hall and car push-buttons, then holds each request as a pending level.
- Drives the controller's `button_out` and `button_in` inputs with those levels.
- Clears a floor's requests when the controller reports that floor as `current_floor` with the door `open`.

Parameters:
- n, 5, number of floors; width of every floor vector.
- DB_CYCLES, 4, consecutive synchronised-high cycles needed to accept a press (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raw_out  input  n  raw hall call buttons, asynchronous, bit i = floor i.
- raw_in  input  n  raw in-car floor-select buttons, asynchronous.
- current_floor  input  n  one-hot car position, from controller.
- open  input  1  door-open indication, from controller.
- button_out  output  n  pending hall requests, registered; to controller.
- button_in  output  n  pending car requests, registered; to controller.
- any_req  output  1  OR of all bits of `button_out` and `button_in`.

Behaviour:
- Reset is asynchronous, active-low, one clock domain. While `rst_n` is 0:
  - all synchroniser flops, debounce counters and debounced levels are 0;
  - `button_out` = 0, `button_in` = 0, `any_req` = 0.
- Operation resumes on the first rising edge after `rst_n` deasserts.
- Reset mid-debounce or with requests pending discards everything; no request survives reset.
- Per raw bit (2n independent channels):
  - 2-flop synchroniser; s = second flop output.
  - Counter cnt, width clog2(DB_CYCLES+1):
    - cnt resets to 0 on any edge where s = 0;
    - otherwise cnt increments, saturating at DB_CYCLES.
  - Debounced level d is registered: d <= (cnt == DB_CYCLES), evaluated on the post-increment value.
  - Press event = d & ~d_q, where d_q is d delayed one cycle.
- Latency, with edge 0 the first edge sampling raw high and raw held high:
  - s = 1 after edge 1;
  - d = 1 after edge DB_CYCLES+1;
  - pending = 1 after edge DB_CYCLES+2 (6 with default).
- A raw high pulse yielding fewer than DB_CYCLES consecutive s = 1 samples produces no event.
- Holding a button produces exactly one event. A new event needs s to return to 0 and then satisfy debounce again.
- Pending update per floor i, each edge, for `button_out[i]` and `button_in[i]` independently:
  - clr_i = open & current_floor[i], sampled this edge.
  - If clr_i: the bit goes to 0, and clear wins over a simultaneous press event for that floor.
  - Else if press event: the bit goes to 1.
  - Else: the bit holds.
- clr_i clears both `button_out[i]` and `button_in[i]` on the same edge.
- A non-one-hot `current_floor` with `open` = 1 clears every floor whose bit is set; this is not an error.
- A press at a floor while its door is open and the car sits there is dropped; the request is already served.
- A press for an already-pending floor has no effect (base build).
- `any_req` is combinational from the output registers only: zero input-to-output combinational path.
- No handshake: outputs are levels the controller samples every cycle.

Optional Feature:
- Macro CALL_CANCEL_EN.
- Defined: a press event on `raw_in[i]` while `button_in[i]` = 1 and clr_i = 0 clears `button_in[i]` (toggle-cancel). Hall calls (`button_out`) are not cancellable.
- Not defined: repeat presses on a pending bit are ignored, as in the base behaviour.

Test Plan:
- Reset: hold `rst_n` = 0 with `raw_out` = 5'b11111 -> all outputs 0 throughout. Release `rst_n` while raw is still high -> `button_out` = 5'b11111 exactly 6 edges after the first sampling edge.
- Glitch filter: `raw_in[2]` high for 3 cycles, then low -> `button_in` stays 5'b00000. `raw_in[2]` high for 10 cycles -> `button_in` = 5'b00100 at edge 6, with a single event.
- Service clear: `button_out` = 5'b01000 and `button_in` = 5'b01001; drive `current_floor` = 5'b01000 and `open` = 1 for one cycle -> `button_out` = 0, `button_in` = 5'b00001, `any_req` still 1.
- Simultaneous set/clear: press event on floor 1 on the same edge as `open` = 1 with `current_floor` = 5'b00010 -> bit 1 remains 0. Press on floor 4 on that edge -> `button_out[4]` = 1.
- Mid-operation reset: pulse `rst_n` low for 5 ns, asynchronous to `clk`, while `raw_out[0]` is 3 cycles into debounce and `button_in` = 5'b10000 -> outputs drop to 0 immediately, before the next clock edge. Debounce restarts from 0, so the pending bit is set 6 edges after release.
- CALL_CANCEL_EN: with `button_in[3]` = 1, re-press `raw_in[3]` for 10 cycles -> `button_in[3]` = 0 when defined, stays 1 when not defined. The same re-press on `raw_out[3]` never clears `button_out[3]`.

Source files
------------

// File: rtl/elevator_call_latch_if.sv
// elevator_call_latch_if
//   Bundles the request-stage signals between the button/controller side and
//   elevator_call_latch.
//
//   master modport (environment / controller side):
//     raw_out       out  n  raw hall call buttons, asynchronous
//     raw_in        out  n  raw in-car floor-select buttons, asynchronous
//     current_floor out  n  one-hot car position
//     open          out  1  door-open indication
//     button_out    in   n  pending hall requests
//     button_in     in   n  pending car requests
//     any_req       in   1  OR of all pending requests
//   slave modport (elevator_call_latch): directions reversed.
interface elevator_call_latch_if #(
  parameter int unsigned n = 5
);
  logic [n-1:0] raw_out;
  logic [n-1:0] raw_in;
  logic [n-1:0] current_floor;
  logic         open;
  logic [n-1:0] button_out;
  logic [n-1:0] button_in;
  logic         any_req;

  modport master (
    output raw_out,
    output raw_in,
    output current_floor,
    output open,
    input  button_out,
    input  button_in,
    input  any_req
  );

  modport slave (
    input  raw_out,
    input  raw_in,
    input  current_floor,
    input  open,
    output button_out,
    output button_in,
    output any_req
  );
endinterface

// File: rtl/elevator_call_latch.sv
// elevator_call_latch
//   Front-end request stage for the elevator controller. Every raw hall and car
//   button is synchronised with two flops, debounced by a saturating counter and
//   turned into a single-cycle press event on the rising edge of the debounced
//   level. Press events set per-floor pending bits which are presented to the
//   controller as button_out / button_in. A floor's pending bits are cleared when
//   the controller reports the car at that floor with the door open; the clear
//   takes priority over a press arriving on the same edge.
//
//   Ports:
//     clk    in  1  system clock, rising edge
//     rst_n  in  1  asynchronous active-low reset
//     bus    slave modport of elevator_call_latch_if:
//              raw_out, raw_in, current_floor, open  (inputs)
//              button_out, button_in, any_req        (outputs)
//
//   Parameters:
//     n          number of floors (width of every floor vector)
//     DB_CYCLES  consecutive synchronised-high cycles required to accept a press
//                (1..255)
//
//   Build option:
//     CALL_CANCEL_EN  when defined, a car-button press on a floor that is already
//                     pending in button_in withdraws that request (toggle-cancel).
//                     Hall calls are never cancellable. When undefined, repeat
//                     presses on a pending bit are ignored.
module elevator_call_latch #(
  parameter int unsigned n         = 5,
  parameter int unsigned DB_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  elevator_call_latch_if.slave bus
);

  // Channels [n-1:0] are hall buttons, [2n-1:n] are car buttons.
  localparam int unsigned Nch  = 2 * n;
  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES);

  logic [Nch-1:0]           raw_all;
  logic [Nch-1:0]           sync1_q;
  logic [Nch-1:0]           sync2_q;
  logic [Nch-1:0][CntW-1:0] cnt_q;
  logic [Nch-1:0][CntW-1:0] cnt_d;
  logic [Nch-1:0]           deb_q;
  logic [Nch-1:0]           deb_d;
  logic [Nch-1:0]           deb_dly_q;
  logic [Nch-1:0]           press;

  logic [n-1:0]             press_out;
  logic [n-1:0]             press_in;
  logic [n-1:0]             clr;
  logic [n-1:0]             out_q;
  logic [n-1:0]             out_d;
  logic [n-1:0]             in_q;
  logic [n-1:0]             in_d;

  assign raw_all = {bus.raw_in, bus.raw_out};

  // Two-flop synchroniser for every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_all;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive synchronised-high cycles, saturating at
  // DB_CYCLES. The debounced level is taken from the post-increment count so it
  // rises on the same edge the count reaches DB_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = '0;
    for (int unsigned c = 0; c < Nch; c++) begin
      if (!sync2_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] != CntMax) begin
        cnt_d[c] = cnt_q[c] + CntW'(1);
      end
      deb_d[c] = (cnt_d[c] == CntMax);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  // One event per accepted press; holding the button keeps deb_q high and
  // produces nothing further until the button is released and debounced again.
  assign press     = deb_q & ~deb_dly_q;
  assign press_out = press[n-1:0];
  assign press_in  = press[Nch-1:n];

  // A non-one-hot current_floor with the door open clears every flagged floor.
  assign clr = bus.current_floor & {n{bus.open}};

  always_comb begin
    // Clear wins over a same-edge press: the car is already serving that floor.
    out_d = (out_q | press_out) & ~clr;
`ifdef CALL_CANCEL_EN
    // Car-button press toggles: sets an idle bit, withdraws a pending one.
    in_d  = (in_q ^ press_in) & ~clr;
`else
    in_d  = (in_q | press_in) & ~clr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      in_q  <= '0;
    end else begin
      out_q <= out_d;
      in_q  <= in_d;
    end
  end

  // Outputs come straight from registers; any_req has no path from the inputs.
  assign bus.button_out = out_q;
  assign bus.button_in  = in_q;
  assign bus.any_req    = |{out_q, in_q};

endmodule
